// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer master: a command port feeds a two-stage address/data
// pipeline, and one response pulse is returned per completed data phase.
module ahb_lite_master #(
  parameter int AW = 16
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic          CMD_WRITE,
  input  logic [AW-1:0] CMD_ADDR,
  input  logic [2:0]    CMD_SIZE,
  input  logic [31:0]   CMD_WDATA,
  output logic          RSP_VALID,
  output logic [31:0]   RSP_RDATA,
  output logic          RSP_ERR,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic [2:0]    HSIZE,
  output logic          HWRITE,
  output logic [2:0]    HBURST,
  output logic [31:0]   HWDATA,
  input  logic          HREADY,
  input  logic          HRESP,
  input  logic [31:0]   HRDATA
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  logic          ap_vld_q,   ap_vld_d;
  logic          ap_write_q, ap_write_d;
  logic [AW-1:0] ap_addr_q,  ap_addr_d;
  logic [2:0]    ap_size_q,  ap_size_d;
  logic [31:0]   ap_wdata_q, ap_wdata_d;
  logic          dp_vld_q,   dp_vld_d;
  logic          dp_write_q, dp_write_d;
  logic [31:0]   dp_wdata_q, dp_wdata_d;
  logic          err_q,      err_d;
  logic          rsp_vld_q,  rsp_vld_d;
  logic          rsp_err_q,  rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          cmd_ready;
  logic          accept;

  // err_q marks the second cycle of a two-cycle ERROR response; the AP is frozen then
  assign cmd_ready = (!ap_vld_q || HREADY) && !err_q && !(dp_vld_q && HRESP);
  assign accept    = CMD_VALID && cmd_ready;

  always_comb begin
    ap_vld_d    = ap_vld_q;
    ap_write_d  = ap_write_q;
    ap_addr_d   = ap_addr_q;
    ap_size_d   = ap_size_q;
    ap_wdata_d  = ap_wdata_q;
    dp_vld_d    = dp_vld_q;
    dp_write_d  = dp_write_q;
    dp_wdata_d  = dp_wdata_q;
    err_d       = 1'b0;
    rsp_vld_d   = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    if (dp_vld_q && HREADY) begin
      rsp_vld_d = 1'b1;
      rsp_err_d = HRESP;
      if (!dp_write_q && !HRESP) rsp_rdata_d = HRDATA;
    end

    if (HREADY) begin
      if (err_q) begin
        dp_vld_d = 1'b0;
      end else begin
        dp_vld_d = ap_vld_q;
        if (ap_vld_q) begin
          dp_write_d = ap_write_q;
          dp_wdata_d = ap_wdata_q;
        end
        ap_vld_d = 1'b0;
      end
    end else begin
      err_d = dp_vld_q && HRESP;
    end

    if (accept) begin
      ap_vld_d   = 1'b1;
      ap_write_d = CMD_WRITE;
      ap_addr_d  = CMD_ADDR;
      ap_size_d  = (CMD_SIZE > 3'd2) ? 3'd2 : CMD_SIZE;
      ap_wdata_d = CMD_WDATA;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ap_vld_q    <= 1'b0;
      ap_write_q  <= 1'b0;
      ap_addr_q   <= '0;
      ap_size_q   <= '0;
      ap_wdata_q  <= '0;
      dp_vld_q    <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_wdata_q  <= '0;
      err_q       <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      ap_vld_q    <= ap_vld_d;
      ap_write_q  <= ap_write_d;
      ap_addr_q   <= ap_addr_d;
      ap_size_q   <= ap_size_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_vld_q    <= dp_vld_d;
      dp_write_q  <= dp_write_d;
      dp_wdata_q  <= dp_wdata_d;
      err_q       <= err_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // AP fields are only rewritten on acceptance, so the bus holds its last values when idle
  assign HTRANS    = (ap_vld_q && !err_q) ? TR_NONSEQ : TR_IDLE;
  assign HADDR     = ap_addr_q;
  assign HSIZE     = ap_size_q;
  assign HWRITE    = ap_write_q;
  assign HBURST    = 3'b000;
  assign HWDATA    = dp_wdata_q;
  assign CMD_READY = cmd_ready;
  assign RSP_VALID = rsp_vld_q;
  assign RSP_ERR   = rsp_err_q;
  assign RSP_RDATA = rsp_rdata_q;

endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 Parameter: AW, default 16, AHB address width.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 HCLK  input  1  system bus clock; all state updates on rising edge.
REQ-004 HRESET  input  1  synchronous active-high reset.
REQ-005 CMD_VALID  input  1  command request.
REQ-006 CMD_READY  output  1  command accepted when CMD_VALID and CMD_READY are both high at a clock edge.
REQ-007 CMD_WRITE  input  1  1 = write, 0 = read.
REQ-008 CMD_ADDR  input  AW  byte address.
REQ-009 CMD_SIZE  input  3  transfer size; only values 0..2 are meaningful.
REQ-010 CMD_WDATA  input  32  write data.
REQ-011 RSP_VALID  output  1  one-cycle completion pulse; no backpressure.
REQ-012 RSP_RDATA  output  32  read data; valid only with RSP_VALID on a read.
REQ-013 RSP_ERR  output  1  slave returned ERROR; valid only with RSP_VALID.
REQ-014 HADDR  output  AW  AHB address.
REQ-015 HTRANS  output  2  AHB transfer type; only IDLE (00) and NONSEQ (10) are driven.
REQ-016 HSIZE  output  3  AHB size.
REQ-017 HWRITE  output  1  AHB direction.
REQ-018 HBURST  output  3  tied to 000 (SINGLE).
REQ-019 HWDATA  output  32  AHB write data.
REQ-020 HREADY  input  1  AHB ready from the slave-to-master mux.
REQ-021 HRESP  input  1  AHB response; 1 = ERROR.
REQ-022 HRDATA  input  32  AHB read data.

Function
REQ-023 Two internal stages: an address-phase register (AP) and a data-phase register (DP), each with a valid bit; the pipelined overlap is full, one transfer per cycle at zero wait states.
REQ-024 CMD_READY is high when the AP is empty or when HREADY is high, and low during any error cycle (REQ-030).
REQ-025 An accepted command loads the AP on the next edge.
- While the AP is valid: HTRANS = NONSEQ, and HADDR, HSIZE and HWRITE are driven from the AP.
- Otherwise: HTRANS = IDLE, and HADDR, HSIZE and HWRITE hold their last values.
REQ-026 A CMD_SIZE value above 2 is stored and driven as 010.
REQ-027 At an edge with HREADY high:
- The AP contents move to the DP; DP valid = AP valid.
- The AP reloads from the command port if a command is accepted; otherwise the AP becomes empty.
REQ-028 HWDATA is driven from the DP write data for the whole data phase and stays stable while HREADY is low.
REQ-029 Data-phase completion is an edge with DP valid, HREADY = 1 and HRESP = 0. On the following cycle, RSP_VALID = 1 and RSP_ERR = 0. For a read, RSP_RDATA = HRDATA sampled at that edge.
REQ-030 ERROR handling:
- An edge with DP valid, HREADY = 0 and HRESP = 1 is the first error cycle.
- On the next cycle, HTRANS = IDLE even if the AP is valid; the pending AP command is held and not lost.
- The second error cycle (HREADY = 1, HRESP = 1) completes the DP with RSP_VALID = 1 and RSP_ERR = 1 on the following cycle.
- After that, the held AP command is reissued as NONSEQ in the address phase.
REQ-031 Responses are returned in command-acceptance order; at most 2 transfers are outstanding.
REQ-032 With both AP and DP valid and HREADY low, CMD_READY is low and all bus outputs hold.
REQ-033 Simultaneous DP completion and command acceptance in the same cycle is legal and loses no response.

Reset
REQ-034 At a HCLK edge with HRESET high, both stages are cleared and outputs take these values:
- HTRANS = 00, HADDR = 0, HSIZE = 000, HWRITE = 0, HWDATA = 0.
- CMD_READY = 1, RSP_VALID = 0, RSP_ERR = 0, RSP_RDATA = 0.
REQ-035 Reset during an outstanding transfer discards it with no response generated; bus outputs are IDLE on the first cycle after reset.

Verification
REQ-036 Single write: CMD write, addr 0x0010, size 2, wdata 0xDEADBEEF, HREADY = 1 -> NONSEQ for one cycle, HWDATA = 0xDEADBEEF the next cycle, RSP_VALID one cycle later with RSP_ERR = 0.
REQ-037 Read with 2 wait states: read 0x0020; HREADY low for 2 data-phase cycles, then HRDATA = 0x12345678 -> RSP_RDATA = 0x12345678; HADDR stable and HTRANS IDLE after the address phase.
REQ-038 Back-to-back: 4 writes presented consecutively with HREADY = 1 -> 4 consecutive NONSEQ cycles, 4 RSP_VALID pulses in order, CMD_READY never low.
REQ-039 Error with pending command: write 0x0030 followed by read 0x0034; slave gives a 2-cycle ERROR on the write -> HTRANS IDLE in the second error cycle, first response RSP_ERR = 1, then the read is reissued and completes with RSP_ERR = 0.
REQ-040 Reset mid-transfer: HRESET asserted while the DP is stalled by HREADY low -> no RSP_VALID, all outputs equal their reset values, and a new command after reset completes normally.
REQ-041 CMD_SIZE = 3'b111 -> HSIZE = 010 on the bus.
